// File: rtl/register_file.sv
// Register file: 1 write port, 2 combinational read ports, optional hardwired-zero entry 0.
// Define REGISTER_FILE_BYPASS_EN to forward a same-cycle write to the read ports.
module register_file #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [WIDTH-1:0]  rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_b
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             wr_hit;
   logic             rd_ok_a, rd_ok_b;
   logic             fwd_a, fwd_b;

   // An address is live if it maps to a real entry and is not the hardwired zero.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
      return ({1'b0, addr} < DEPTH_X) && !((ZERO_REG != 0) && (addr == '0));
   endfunction

   assign wr_hit  = wr_en && addr_ok(wr_addr);
   assign rd_ok_a = addr_ok(rd_addr_a);
   assign rd_ok_b = addr_ok(rd_addr_b);

   // NOTE: next state is built with blocking assignments in always_comb; state updates use <= only.
   always_comb begin
      mem_d = mem_q;
      if (wr_hit) begin
         mem_d[wr_addr[IDX_W-1:0]] = wr_data;
      end
   end

   // NOTE: every entry is reset because reads of never-written entries must return zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

`ifdef REGISTER_FILE_BYPASS_EN
   assign fwd_a = wr_hit && !reset && (rd_addr_a == wr_addr);
   assign fwd_b = wr_hit && !reset && (rd_addr_b == wr_addr);
`else
   assign fwd_a = 1'b0;
   assign fwd_b = 1'b0;
`endif

   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      if (fwd_a) begin
         rd_data_a = wr_data;
      end else if (rd_ok_a) begin
         rd_data_a = mem_q[rd_addr_a[IDX_W-1:0]];
      end
      if (fwd_b) begin
         rd_data_b = wr_data;
      end else if (rd_ok_b) begin
         rd_data_b = mem_q[rd_addr_b[IDX_W-1:0]];
      end
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data bits per entry (legal 1..64).
REQ-002 SHALL provide parameter DEPTH, default 32, number of entries (legal 2..2^ADDR_W).
REQ-003 SHALL provide parameter ADDR_W, default 5, address bits per port.
REQ-004 SHALL provide parameter ZERO_REG, default 1; when 1, entry 0 is hardwired zero.
REQ-005 SHALL have port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port wr_en, input, 1 bit, write enable.
REQ-008 SHALL have port wr_addr, input, ADDR_W bits, write address.
REQ-009 SHALL have port wr_data, input, WIDTH bits, write data.
REQ-010 SHALL have port rd_addr_a, input, ADDR_W bits, read port A address.
REQ-011 SHALL have port rd_data_a, output, WIDTH bits, read port A data.
REQ-012 SHALL have port rd_addr_b, input, ADDR_W bits, read port B address.
REQ-013 SHALL have port rd_data_b, output, WIDTH bits, read port B data.

Function
REQ-014 SHALL store DEPTH entries of WIDTH bits each.
REQ-015 SHALL, at a rising clk edge with reset=0 and wr_en=1, write wr_data to the entry at wr_addr.
REQ-016 SHALL leave all entries unchanged at a rising clk edge with wr_en=0.
REQ-017 SHALL drive rd_data_a/rd_data_b combinationally from rd_addr_a/rd_addr_b, with zero cycles of latency.
REQ-018 SHALL make a written value visible on the read ports from the cycle after the write edge onward.
REQ-019 SHALL, with ZERO_REG=1, ignore writes to address 0 and always return 0 on a read of address 0.
REQ-020 SHALL, with ZERO_REG=0, treat entry 0 as an ordinary entry.
REQ-021 SHALL ignore writes with wr_addr >= DEPTH; no entry changes and no aliasing.
REQ-022 SHALL return all-zero on a read with an address >= DEPTH.
REQ-023 SHALL allow both read ports to address the same entry at once; both return the identical value.
REQ-024 SHALL give each read port independent, non-interfering behaviour.

Reset
REQ-025 SHALL clear every entry to 0 on a rising clk edge with reset=1.
REQ-026 SHALL give reset priority over a write in the same cycle; the write is discarded.
REQ-027 SHALL leave read outputs combinational during reset; they reflect stored contents, which are all-zero from the first reset edge onward.
REQ-028 SHALL resume normal writes on the first edge with reset=0, without a recovery cycle.

Configuration
REQ-029 SHALL honour the macro REGISTER_FILE_BYPASS_EN.
REQ-030 SHALL, with REGISTER_FILE_BYPASS_EN defined, forward the same-cycle write: when wr_en=1 and reset=0, a read port whose address equals wr_addr returns wr_data. Forwarding excludes two cases: address 0 with ZERO_REG=1, and wr_addr >= DEPTH.
REQ-031 SHALL, with REGISTER_FILE_BYPASS_EN undefined, return only the stored value; a same-cycle write is not seen until the next cycle.
REQ-032 SHALL, in either configuration, give every other requirement identical behaviour.

Verification
REQ-033 SHALL cover write then read: write 0xDEADBEEF to addr 5, then read A=5, B=5 next cycle -> both 0xDEADBEEF.
REQ-034 SHALL cover the zero register: with ZERO_REG=1, write 0x12345678 to addr 0 -> read addr 0 returns 0x00000000; with ZERO_REG=0 the same stimulus -> 0x12345678.
REQ-035 SHALL cover reset: fill addrs 1..31 with distinct values, assert reset one cycle together with a write of 0xFFFFFFFF to addr 3 -> all reads return 0, addr 3 also 0.
REQ-036 SHALL cover bypass: addr 7 holds 0x1, write 0xA5A5A5A5 to addr 7 while rd_addr_a=7 -> same cycle 0xA5A5A5A5 with the macro defined, 0x00000001 without it; next cycle 0xA5A5A5A5 in both.
REQ-037 SHALL cover out of range: DEPTH=20, ADDR_W=5, write 0xCAFE to addr 25 -> read addr 25 returns 0, and addrs 9 and 5 are unchanged.
REQ-038 SHALL cover a parameter sweep: WIDTH=8, DEPTH=4, ADDR_W=2, write 0xFF to addr 3 and 0x80 to addr 1 -> A=3 returns 0xFF, B=1 returns 0x80.
